// File: rtl/fir_decim_out.sv
// Decimating output stage for the 3-tap FIR: averages DECIM samples, rescales to
// 8 bits with one rounding step and saturation, and buffers results in a show-ahead FIFO.
module fir_decim_out #(
    parameter int DECIM      = 4,
    parameter int SHIFT      = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [15:0]                   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int KD    = $clog2(DECIM);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int ACCW  = 16 + KD;
    localparam int SW    = ACCW + 1;
    localparam int K     = KD + SHIFT;
    localparam int KR    = (K == 0) ? 0 : K - 1;
    localparam logic [SW-1:0] ROUND = (K == 0) ? '0 : (SW'(1) << KR);

    logic [KD-1:0]   phase_q, phase_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] groupSum;
    logic            lastSample;
    logic [SW-1:0]   rounded;
    logic [SW-1:0]   scaled;
    logic [7:0]      result;

    logic [7:0]      stage_q, stage_d;
    logic            resPend_q, resPend_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            fifoFull;
    logic            doPop;
    logic            doPush;

    // Group sum includes the current sample so the final edge needs no extra cycle.
    always_comb begin
        lastSample = in_valid && (phase_q == KD'(DECIM - 1));
        groupSum   = acc_q + ACCW'(in_data);
        rounded    = SW'(groupSum) + ROUND;
        scaled     = rounded >> K;
        result     = (|scaled[SW-1:8]) ? 8'hFF : scaled[7:0];
    end

    always_comb begin
        phase_d   = phase_q;
        acc_d     = acc_q;
        stage_d   = stage_q;
        resPend_d = 1'b0;
        if (in_valid) begin
            if (lastSample) begin
                phase_d   = '0;
                acc_d     = '0;
                stage_d   = result;
                resPend_d = 1'b1;
            end else begin
                phase_d = phase_q + KD'(1);
                acc_d   = groupSum;
            end
        end
    end

    // A full FIFO still accepts the pending result when the head leaves on the same edge.
    always_comb begin
        fifoFull   = (level_q == LW'(FIFO_DEPTH));
        doPop      = out_valid && out_ready;
        doPush     = resPend_q && (!fifoFull || doPop);
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (doPush && !doPop) begin
            level_d = level_q + LW'(1);
        end else if (doPop && !doPush) begin
            level_d = level_q - LW'(1);
        end
        if (resPend_q && !doPush) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            acc_q      <= '0;
            stage_q    <= '0;
            resPend_q  <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            stage_q    <= stage_d;
            resPend_q  <= resPend_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && doPush) begin
            mem_q[wrPtr_q] <= stage_q;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rdPtr_q] : 8'h00;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Scoreboard bench for fir_decim_out (DECIM=4, SHIFT=3, FIFO_DEPTH=8): expected
// results are queued when a group's final sample is driven and checked on each pop.
module tb_fir_decim_out;

    localparam int K = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  fifo_level;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;
    int expq[$];
    int expv;

    fir_decim_out #(.DECIM(4), .SHIFT(3), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic int expect_result(input int sum);
        int r;
        r = (sum + (1 << (K - 1))) >> K;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Each accepted pop is checked against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pop_unexpected: got out_data=%0d, expected no output", out_data);
            end else begin
                expv = expq.pop_front();
                if (out_data !== 8'(expv)) begin
                    miscompares++;
                    $display("[TB] FAIL pop_data: got %0d, expected %0d", out_data, expv);
                end
            end
        end
    end

    task automatic feed_group(input int d0, input int d1, input int d2, input int d3,
                              input int gap, input bit keep);
        int d[4];
        int sum;
        d   = '{d0, d1, d2, d3};
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(d[i]);
            sum     += d[i];
            if (i == 3 && keep) expq.push_back(expect_result(sum));
            tick;
            in_valid = 1'b0;
            if (i < 3) repeat (gap) tick;
        end
    endtask

    task automatic test_reset;
        out_ready = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            tick;
            vectors++;
            if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 || out_data !== 8'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_state: got valid=%b level=%0d ovf=%b data=%0d, expected 0 0 0 0",
                         out_valid, fifo_level, overflow, out_data);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            vectors++;
            if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_state: cycle %0d got valid=%b level=%0d ovf=%b, expected 0 0 0",
                         c, out_valid, fifo_level, overflow);
            end
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        feed_group(100, 100, 100, 100, 0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL latency_edge1: got out_valid=%b, expected 0", out_valid);
        end
        tick;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd13) begin
            miscompares++;
            $display("[TB] FAIL latency_edge2: got valid=%b data=%0d, expected 1 13", out_valid, out_data);
        end
        feed_group(1530, 1530, 1530, 1530, 0, 1'b1);
        repeat (4) tick;
        vectors++;
        if (expq.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_drain: got pending=%0d valid=%b, expected 0 0", expq.size(), out_valid);
        end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hFFFF;
        repeat (3) tick;
        #1;
        vectors++;
        if (dut.groupSum !== 18'd262140) begin
            miscompares++;
            $display("[TB] FAIL sat_sum: got %0d, expected 262140", dut.groupSum);
        end
        expq.push_back(255);
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sat_drain: got pending=%0d, expected 0", expq.size());
        end
    endtask

    task automatic test_gaps;
        int d[4];
        d = '{10, 20, 30, 40};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(d[i]);
            if (i == 3) expq.push_back(expect_result(100));
            tick;
            in_valid = 1'b0;
            repeat (3) tick;
            vectors++;
            if (dut.phase_q !== 2'((i + 1) % 4)) begin
                miscompares++;
                $display("[TB] FAIL gap_phase: after sample %0d got %0d, expected %0d", i, dut.phase_q, (i + 1) % 4);
            end
        end
        repeat (3) tick;
        vectors++;
        if (expq.size() != 0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL gap_result: got pending=%0d level=%0d, expected 0 0", expq.size(), fifo_level);
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        for (int g = 1; g <= 9; g++) begin
            feed_group(32 * g, 32 * g, 32 * g, 32 * g, 0, g <= 8);
            if (g == 8) begin
                tick;
                vectors++;
                if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL ovf_fill: got level=%0d ovf=%b, expected 8 0", fifo_level, overflow);
                end
            end
        end
        repeat (2) tick;
        vectors++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_drop: got level=%0d ovf=%b, expected 8 1", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && out_valid === 1'b1; c++) tick;
        vectors++;
        if (out_valid !== 1'b0 || expq.size() != 0 || overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_drain: got valid=%b pending=%0d ovf=%b, expected 0 0 1",
                     out_valid, expq.size(), overflow);
        end
    endtask

    task automatic test_full_pushpop;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear: got %b, expected 0", overflow);
        end
        out_ready = 1'b0;
        for (int g = 1; g <= 8; g++) feed_group(40 * g + 7, 40 * g + 7, 40 * g + 7, 40 * g + 7, 0, 1'b1);
        tick;
        vectors++;
        if (fifo_level !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL pp_fill: got level=%0d, expected 8", fifo_level);
        end
        feed_group(367, 367, 367, 367, 0, 1'b1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vectors++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pp_level: got level=%0d ovf=%b, expected 8 0", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && out_valid === 1'b1; c++) tick;
        vectors++;
        if (out_valid !== 1'b0 || expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pp_drain: got valid=%b pending=%0d, expected 0 0", out_valid, expq.size());
        end
    endtask

    task automatic test_midrun_reset;
        out_ready = 1'b1;
        feed_group(3000, 3000, 3000, 3000, 0, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (2) tick;
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_pending: got valid=%b level=%0d, expected 0 0", out_valid, fifo_level);
        end
        in_valid = 1'b1;
        in_data  = 16'd5000;
        repeat (2) tick;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if (dut.phase_q !== 2'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_midgroup: got phase=%0d valid=%b, expected 0 0", dut.phase_q, out_valid);
        end
        out_ready = 1'b0;
        feed_group(200, 200, 200, 200, 0, 1'b1);
        tick;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd25) begin
            miscompares++;
            $display("[TB] FAIL rst_fresh: got valid=%b data=%0d, expected 1 25", out_valid, out_data);
        end
        out_ready = 1'b1;
        repeat (3) tick;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset;
        test_basic;
        test_saturation;
        test_gaps;
        test_overflow;
        test_full_pushpop;
        test_midrun_reset;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL final_queue: got %0d pending results, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
